// File: rtl/even_issue_ctrl_pkg.sv
// Shared types and constants for the even-pipe issue controller: unit ids,
// forwarding select codes and the in-flight tracker entry.
package even_pipe_pkg;

    localparam int NUM_STAGES  = 7;
    localparam int TRACK_DEPTH = NUM_STAGES + 1;   // stages 1..7 plus WB

    localparam logic [2:0] UNIT_FX1  = 3'b000;
    localparam logic [2:0] UNIT_FX2  = 3'b001;
    localparam logic [2:0] UNIT_SP   = 3'b010;
    localparam logic [2:0] UNIT_BYTE = 3'b011;

    localparam logic [3:0] FWD_RF  = 4'd0;
    localparam logic [3:0] FWD_WB  = 4'd8;
    localparam logic [3:0] LAT_MAX = 4'd7;

    typedef struct packed {
        logic       valid;
        logic       reg_wr;
        logic [6:0] reg_dst;
        logic [3:0] latency;
    } track_entry_t;

    // Out-of-range latency or an unknown unit is issued as the slowest unit.
    function automatic logic is_illegal(input logic [2:0] unit_id, input logic [3:0] latency);
        return (latency == 4'd0) || (latency > LAT_MAX) || (unit_id > UNIT_BYTE);
    endfunction

endpackage

// File: rtl/even_issue_ctrl_if.sv
// Issue-slot bundle between decode/register-fetch (master) and the even-pipe
// issue controller (slave).
interface even_issue_ctrl_if;

    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] unit_id;
    logic [3:0] latency;
    logic [6:0] reg_dst;
    logic       reg_wr;
    logic [6:0] ra_addr;
    logic [6:0] rb_addr;
    logic [6:0] rc_addr;
    logic       ra_use;
    logic       rb_use;
    logic       rc_use;
    logic [3:0] fwd_sel_ra;
    logic [3:0] fwd_sel_rb;
    logic [3:0] fwd_sel_rc;

    modport master (
        output issue_valid, unit_id, latency, reg_dst, reg_wr,
               ra_addr, rb_addr, rc_addr, ra_use, rb_use, rc_use,
        input  issue_ready, fwd_sel_ra, fwd_sel_rb, fwd_sel_rc
    );

    modport slave (
        input  issue_valid, unit_id, latency, reg_dst, reg_wr,
               ra_addr, rb_addr, rc_addr, ra_use, rb_use, rc_use,
        output issue_ready, fwd_sel_ra, fwd_sel_rb, fwd_sel_rc
    );

endinterface

// File: rtl/even_issue_ctrl_operand_check.sv
// Per-operand RAW check: youngest-first scan of the tracker producing stall and
// forwarding select. EVEN_FWD_EN enables forwarding; otherwise any match stalls.
module even_operand_check
    import even_pipe_pkg::*;
(
    input  track_entry_t tracker [1:TRACK_DEPTH],
    input  logic [6:0]   src_addr,
    input  logic         src_use,
    output logic         stall,
    output logic [3:0]   fwd_sel
);

    logic found;
`ifndef EVEN_FWD_EN
    logic unused_lat;
`endif

    // NOTE: every output gets a default before the scan so no latch is inferred.
    always_comb begin
        stall   = 1'b0;
        fwd_sel = FWD_RF;
        found   = 1'b0;
        for (int age = 1; age <= TRACK_DEPTH; age++) begin
            if (!found && src_use && tracker[age].valid && tracker[age].reg_wr &&
                tracker[age].reg_dst == src_addr) begin
                found = 1'b1;
`ifdef EVEN_FWD_EN
                if (4'(age) < tracker[age].latency)
                    stall = 1'b1;
                else
                    fwd_sel = 4'(age);
`else
                stall = 1'b1;
`endif
            end
        end
    end

`ifndef EVEN_FWD_EN
    // Without forwarding the result is only taken from the RF after WB.
    always_comb begin
        unused_lat = 1'b0;
        for (int age = 1; age <= TRACK_DEPTH; age++)
            unused_lat = unused_lat ^ (^tracker[age].latency);
    end
`endif

endmodule

// File: rtl/even_issue_ctrl.sv
// Even-pipe issue controller: tracks in-flight results for ages 1..8, stalls
// on RAW hazards and drives forwarding selects. Forwarding enabled by EVEN_FWD_EN.
module even_issue_ctrl
    import even_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    even_issue_ctrl_if.slave  bus,
    output logic              lat_err,
    output logic [CNT_W-1:0]  stall_cnt
);

    track_entry_t tracker [1:TRACK_DEPTH];
    track_entry_t new_entry;
    logic         lat_illegal;
    logic         stall_ra, stall_rb, stall_rc;
    logic [3:0]   fwd_ra, fwd_rb, fwd_rc;
    logic         accept;

    even_operand_check u_chk_ra (
        .tracker  (tracker),
        .src_addr (bus.ra_addr),
        .src_use  (bus.ra_use),
        .stall    (stall_ra),
        .fwd_sel  (fwd_ra)
    );

    even_operand_check u_chk_rb (
        .tracker  (tracker),
        .src_addr (bus.rb_addr),
        .src_use  (bus.rb_use),
        .stall    (stall_rb),
        .fwd_sel  (fwd_rb)
    );

    even_operand_check u_chk_rc (
        .tracker  (tracker),
        .src_addr (bus.rc_addr),
        .src_use  (bus.rc_use),
        .stall    (stall_rc),
        .fwd_sel  (fwd_rc)
    );

    assign accept          = bus.issue_valid && !(stall_ra || stall_rb || stall_rc);
    assign bus.issue_ready = accept;

    // Selects are only meaningful for an instruction that actually issues.
    assign bus.fwd_sel_ra = accept ? fwd_ra : FWD_RF;
    assign bus.fwd_sel_rb = accept ? fwd_rb : FWD_RF;
    assign bus.fwd_sel_rc = accept ? fwd_rc : FWD_RF;

    always_comb begin
        lat_illegal       = is_illegal(bus.unit_id, bus.latency);
        new_entry.valid   = 1'b1;
        new_entry.reg_wr  = bus.reg_wr;
        new_entry.reg_dst = bus.reg_dst;
        new_entry.latency = lat_illegal ? LAT_MAX : bus.latency;
    end

    // NOTE: state updates use <= so every age shifts from pre-edge contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= TRACK_DEPTH; k++)
                tracker[k] <= '0;
            lat_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            tracker[1] <= accept ? new_entry : '0;
            for (int k = 2; k <= TRACK_DEPTH; k++)
                tracker[k] <= tracker[k-1];
            if (accept && lat_illegal)
                lat_err <= 1'b1;
            if (bus.issue_valid && !accept && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_even_issue_ctrl.sv
// Scoreboard bench for even_issue_ctrl: directed issues push expected stall
// count and selects; a negedge monitor compares each accepted instruction.
module tb_even_issue_ctrl;
    import even_pipe_pkg::*;

    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef EVEN_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        string      name;
        int         stalls;
        logic [3:0] fa;
        logic [3:0] fb;
        logic [3:0] fc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             lat_err;
    logic [CNT_W-1:0] stall_cnt;
    even_issue_ctrl_if bus ();

    exp_t sb[$];
    int   errors;
    int   checks;
    int   exp_stall_total;

    even_issue_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .lat_err   (lat_err),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic drive_idle();
        bus.issue_valid = 1'b0;
        bus.unit_id = UNIT_FX1;
        bus.latency = 4'd1;
        bus.reg_dst = 7'd0;
        bus.reg_wr  = 1'b0;
        bus.ra_addr = 7'd0; bus.ra_use = 1'b0;
        bus.rb_addr = 7'd0; bus.rb_use = 1'b0;
        bus.rc_addr = 7'd0; bus.rc_use = 1'b0;
    endtask

    task automatic idle(input int n);
        drive_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction, hold until accepted (bounded), return #1 after the accept edge.
    task automatic issue(input string name, input logic [2:0] unit, input logic [3:0] lat,
                         input logic [6:0] dst, input logic wr,
                         input logic [6:0] ra, input logic ua,
                         input logic [6:0] rb, input logic ub,
                         input logic [6:0] rc, input logic uc,
                         input int exp_stalls,
                         input logic [3:0] efa, input logic [3:0] efb, input logic [3:0] efc);
        bit done;
        sb.push_back('{name, exp_stalls, efa, efb, efc});
        exp_stall_total += exp_stalls;
        bus.unit_id = unit; bus.latency = lat; bus.reg_dst = dst; bus.reg_wr = wr;
        bus.ra_addr = ra; bus.ra_use = ua;
        bus.rb_addr = rb; bus.rb_use = ub;
        bus.rc_addr = rc; bus.rc_use = uc;
        bus.issue_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.issue_ready) done = 1'b1;
        end
        check({name, " accepted"}, 32'(done), 32'd1);
        if (!done) void'(sb.pop_back());
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // Monitor: counts stall cycles and compares each accepted instruction.
    initial begin
        int   stalls;
        exp_t e;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalls = 0;
            end else if (bus.issue_valid && !bus.issue_ready) begin
                stalls++;
                check("fwd_sel while stalled", {20'd0, bus.fwd_sel_ra, bus.fwd_sel_rb, bus.fwd_sel_rc}, 32'd0);
            end else if (bus.issue_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected accept: got accept expected none");
                end else begin
                    e = sb.pop_front();
                    check({e.name, " stalls"}, 32'(stalls), 32'(e.stalls));
                    check({e.name, " fwd_sel_ra"}, 32'(bus.fwd_sel_ra), 32'(e.fa));
                    check({e.name, " fwd_sel_rb"}, 32'(bus.fwd_sel_rb), 32'(e.fb));
                    check({e.name, " fwd_sel_rc"}, 32'(bus.fwd_sel_rc), 32'(e.fc));
                end
                stalls = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        exp_stall_total = 0;
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset issue_ready", 32'(bus.issue_ready), 32'd0);
        check("reset lat_err", 32'(lat_err), 32'd0);
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);

        // Short-latency producer followed by a dependent reader.
        issue("fx1 dst5 lat2", UNIT_FX1, 4'd2, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("read ra5", UNIT_FX1, 4'd2, 7'd6, 1'b1, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0,
              FWD ? 1 : 8, FWD ? 4'd2 : 4'd0, 4'd0, 4'd0);
        idle(10);

        // Longest legal latency, back-to-back reader on rb.
        issue("sp dst9 lat7", UNIT_SP, 4'd7, 7'd9, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("read rb9", UNIT_FX1, 4'd1, 7'd10, 1'b1, 7'd0, 1'b0, 7'd9, 1'b1, 7'd0, 1'b0,
              FWD ? 6 : 8, 4'd0, FWD ? 4'd7 : 4'd0, 4'd0);
        check("stall_cnt after lat7", 32'(stall_cnt), 32'(sat(exp_stall_total)));
        idle(10);

        // Two writers of r3 at ages 4 and 1: the youngest wins.
        issue("dst3 first", UNIT_FX1, 4'd1, 7'd3, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("dst40", UNIT_FX2, 4'd1, 7'd40, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("dst41", UNIT_FX2, 4'd1, 7'd41, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("dst3 second", UNIT_BYTE, 4'd1, 7'd3, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("read rc3", UNIT_FX1, 4'd1, 7'd42, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd3, 1'b1,
              FWD ? 0 : 8, 4'd0, 4'd0, FWD ? 4'd1 : 4'd0);
        idle(10);

        // Latency 0 is illegal: flagged and treated as latency 7.
        check("lat_err before illegal", 32'(lat_err), 32'd0);
        issue("dst12 lat0", UNIT_FX2, 4'd0, 7'd12, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        check("lat_err after lat0", 32'(lat_err), 32'd1);
        issue("read ra12", UNIT_FX1, 4'd1, 7'd13, 1'b1, 7'd12, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0,
              FWD ? 6 : 8, FWD ? 4'd7 : 4'd0, 4'd0, 4'd0);
        check("lat_err sticky", 32'(lat_err), 32'd1);
        idle(10);

        // Unused operands, non-writing producer and self-reference never stall.
        issue("dst30", UNIT_FX1, 4'd3, 7'd30, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("unused ra/rb 30", UNIT_FX1, 4'd1, 7'd31, 1'b0, 7'd30, 1'b0, 7'd30, 1'b0, 7'd30, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("read ra31 no wr", UNIT_FX1, 4'd1, 7'd32, 1'b1, 7'd31, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("self dst50 ra50", UNIT_FX1, 4'd2, 7'd50, 1'b1, 7'd50, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        idle(10);

        // Two producers, reader waits on the slower and forwards both.
        issue("dst60 lat3", UNIT_FX1, 4'd3, 7'd60, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("dst61 lat5", UNIT_SP, 4'd5, 7'd61, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        issue("read ra60 rb61", UNIT_FX1, 4'd1, 7'd62, 1'b1, 7'd60, 1'b1, 7'd61, 1'b1, 7'd0, 1'b0,
              FWD ? 4 : 8, FWD ? 4'd6 : 4'd0, FWD ? 4'd5 : 4'd0, 4'd0);
        check("stall_cnt saturating", 32'(stall_cnt), 32'(sat(exp_stall_total)));
        check("lat_err still set", 32'(lat_err), 32'd1);

        // Reset mid-stream discards the in-flight r5 producer.
        issue("dst5 before rst", UNIT_SP, 4'd7, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_stall_total = 0;
        check("mid rst lat_err", 32'(lat_err), 32'd0);
        check("mid rst stall_cnt", 32'(stall_cnt), 32'd0);
        check("mid rst fwd_sel", {20'd0, bus.fwd_sel_ra, bus.fwd_sel_rb, bus.fwd_sel_rc}, 32'd0);
        issue("read ra5 after rst", UNIT_FX1, 4'd1, 7'd7, 1'b1, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);

        // Illegal unit id with legal latency still issues as latency 7.
        issue("unit5 dst70", 3'd5, 4'd2, 7'd70, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 0, 4'd0, 4'd0, 4'd0);
        check("lat_err illegal unit", 32'(lat_err), 32'd1);
        issue("read ra70", UNIT_FX1, 4'd1, 7'd71, 1'b1, 7'd70, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0,
              FWD ? 6 : 8, FWD ? 4'd7 : 4'd0, 4'd0, 4'd0);
        check("stall_cnt after rst", 32'(stall_cnt), 32'(sat(exp_stall_total)));

        idle(10);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
